fu_result_merge: RTL and testbench

- Reverse path of the issue-side lane split. Collects results from the three execute lanes (simple ALU, complex/multi-cycle, FP) and merges them onto one writeback/bypass port.
- Each lane has its own small FIFO, so a stalled writeback port never blocks a lane's producer mid-operation until that FIFO fills.
- A round-robin arbiter drains the lane FIFOs into a single registered output stage with a valid/ready handshake.
- A synchronous flush discards all buffered results on pipeline recovery.

---
 rtl/fu_result_merge.sv | 194 +++++++++++++++++++
 tb/tb_fu_result_merge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_result_merge.sv
// Merges simple / complex / FP execute-lane results onto one writeback port
// through per-lane FIFOs, a round-robin arbiter and a registered output stage.
module fu_result_merge #(
  parameter int PKT_W = 80,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             simple_valid_i,
  input  logic [PKT_W-1:0] simple_pkt_i,
  output logic             simple_ready_o,
  input  logic             complex_valid_i,
  input  logic [PKT_W-1:0] complex_pkt_i,
  output logic             complex_ready_o,
  input  logic             fp_valid_i,
  input  logic [PKT_W-1:0] fp_pkt_i,
  output logic             fp_ready_o,
  output logic             out_valid_o,
  output logic [PKT_W-1:0] out_pkt_o,
  output logic [1:0]       out_lane_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] simple_cnt_o,
  output logic [CNT_W-1:0] complex_cnt_o,
  output logic [CNT_W-1:0] fp_cnt_o
);

  localparam int NL    = 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PKT_W-1:0] mem_r    [NL][DEPTH];
  logic [PTR_W-1:0] rd_ptr_r [NL];
  logic [PTR_W-1:0] wr_ptr_r [NL];
  logic [CNT_W-1:0] cnt_r    [NL];
  logic [PKT_W-1:0] in_pkt_s [NL];

  logic [NL-1:0]    in_valid_s;
  logic [NL-1:0]    ready_s;
  logic [NL-1:0]    nonempty_s;
  logic [NL-1:0]    push_s;
  logic [NL-1:0]    pop_s;
  logic [1:0]       rr_ptr_r;
  logic [1:0]       cand0_s, cand1_s, cand2_s;
  logic [1:0]       grant_lane_s;
  logic [1:0]       rr_next_s;
  logic             grant_valid_s;
  logic             load_en_s;
  logic [PKT_W-1:0] head_pkt_s;
  logic             out_valid_r;
  logic [PKT_W-1:0] out_pkt_r;
  logic [1:0]       out_lane_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Lane index arithmetic modulo 3.
  function automatic logic [1:0] lane_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      lane_add = 2'(sum - 3'd3);
    end else begin
      lane_add = sum[1:0];
    end
  endfunction

  assign in_valid_s  = {fp_valid_i, complex_valid_i, simple_valid_i};
  assign in_pkt_s[0] = simple_pkt_i;
  assign in_pkt_s[1] = complex_pkt_i;
  assign in_pkt_s[2] = fp_pkt_i;

  // Per-lane status; ready comes from the registered count only, no dequeue credit.
  always_comb begin
    ready_s    = 3'b000;
    nonempty_s = 3'b000;
    push_s     = 3'b000;
    for (int k = 0; k < NL; k++) begin
      ready_s[k]    = (cnt_r[k] < FULL_CNT);
      nonempty_s[k] = (cnt_r[k] != {CNT_W{1'b0}});
      push_s[k]     = in_valid_s[k] && ready_s[k] && !flush_i;
    end
  end

  // Round-robin search starting at rr_ptr and the resulting pop.
  always_comb begin
    load_en_s     = (!out_valid_r || out_ready_i) && !flush_i;
    cand0_s       = rr_ptr_r;
    cand1_s       = lane_add(rr_ptr_r, 2'd1);
    cand2_s       = lane_add(rr_ptr_r, 2'd2);
    grant_valid_s = 1'b0;
    grant_lane_s  = 2'd0;
    if (nonempty_s[cand0_s]) begin
      grant_valid_s = 1'b1;
      grant_lane_s  = cand0_s;
    end else if (nonempty_s[cand1_s]) begin
      grant_valid_s = 1'b1;
      grant_lane_s  = cand1_s;
    end else if (nonempty_s[cand2_s]) begin
      grant_valid_s = 1'b1;
      grant_lane_s  = cand2_s;
    end else begin
      grant_valid_s = 1'b0;
      grant_lane_s  = 2'd0;
    end
    rr_next_s  = lane_add(grant_lane_s, 2'd1);
    head_pkt_s = mem_r[grant_lane_s][rd_ptr_r[grant_lane_s]];
    if (grant_valid_s && load_en_s) begin
      pop_s = 3'b001 << grant_lane_s;
    end else begin
      pop_s = 3'b000;
    end
  end

  // FIFO storage; contents are qualified by the counts so need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= in_pkt_s[k];
      end
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NL; k++) begin
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        cnt_r[k]    <= {CNT_W{1'b0}};
      end
    end else if (flush_i) begin
      for (int k = 0; k < NL; k++) begin
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        cnt_r[k]    <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= ptr_inc(wr_ptr_r[k]);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= ptr_inc(rd_ptr_r[k]);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   cnt_r[k] <= cnt_r[k] + CNT_W'(1);
          2'b01:   cnt_r[k] <= cnt_r[k] - CNT_W'(1);
          default: cnt_r[k] <= cnt_r[k];
        endcase
      end
    end
  end

  // Output stage and round-robin pointer; flush leaves pkt/lane stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_pkt_r   <= {PKT_W{1'b0}};
      out_lane_r  <= 2'd0;
      rr_ptr_r    <= 2'd0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
      rr_ptr_r    <= 2'd0;
    end else if (load_en_s) begin
      if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_pkt_r   <= head_pkt_s;
        out_lane_r  <= grant_lane_s;
        rr_ptr_r    <= rr_next_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign simple_ready_o  = ready_s[0];
  assign complex_ready_o = ready_s[1];
  assign fp_ready_o      = ready_s[2];
  assign simple_cnt_o    = cnt_r[0];
  assign complex_cnt_o   = cnt_r[1];
  assign fp_cnt_o        = cnt_r[2];
  assign out_valid_o     = out_valid_r;
  assign out_pkt_o       = out_pkt_r;
  assign out_lane_o      = out_lane_r;

endmodule

// File: tb/tb_fu_result_merge.sv
// Scoreboard bench for fu_result_merge: per-lane expected queues filled on
// accepted enqueues and drained as the output stage hands results over.
module tb_fu_result_merge;

  localparam int PKT_W = 80;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] DEPTH_C = 2'd2;

  logic             clk;
  logic             reset;
  logic             flush_i;
  logic             simple_valid_i, complex_valid_i, fp_valid_i;
  logic [PKT_W-1:0] simple_pkt_i, complex_pkt_i, fp_pkt_i;
  logic             simple_ready_o, complex_ready_o, fp_ready_o;
  logic             out_valid_o;
  logic [PKT_W-1:0] out_pkt_o;
  logic [1:0]       out_lane_o;
  logic             out_ready_i;
  logic [CNT_W-1:0] simple_cnt_o, complex_cnt_o, fp_cnt_o;

  int total;
  int bad;

  logic [PKT_W-1:0] q_s[$];
  logic [PKT_W-1:0] q_c[$];
  logic [PKT_W-1:0] q_f[$];

  fu_result_merge #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .simple_valid_i(simple_valid_i), .simple_pkt_i(simple_pkt_i), .simple_ready_o(simple_ready_o),
    .complex_valid_i(complex_valid_i), .complex_pkt_i(complex_pkt_i), .complex_ready_o(complex_ready_o),
    .fp_valid_i(fp_valid_i), .fp_pkt_i(fp_pkt_i), .fp_ready_o(fp_ready_o),
    .out_valid_o(out_valid_o), .out_pkt_o(out_pkt_o), .out_lane_o(out_lane_o),
    .out_ready_i(out_ready_i),
    .simple_cnt_o(simple_cnt_o), .complex_cnt_o(complex_cnt_o), .fp_cnt_o(fp_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs and outputs are stable at the falling edge and apply at the next rising edge.
  always @(negedge clk) begin
    logic [PKT_W-1:0] exp_pkt;
    logic have;
    if (!reset || flush_i) begin
      q_s.delete();
      q_c.delete();
      q_f.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        have = 1'b0;
        exp_pkt = '0;
        if (out_lane_o == 2'd0 && q_s.size() > 0) begin
          exp_pkt = q_s.pop_front(); have = 1'b1;
        end else if (out_lane_o == 2'd1 && q_c.size() > 0) begin
          exp_pkt = q_c.pop_front(); have = 1'b1;
        end else if (out_lane_o == 2'd2 && q_f.size() > 0) begin
          exp_pkt = q_f.pop_front(); have = 1'b1;
        end
        total++;
        if (!have) begin
          bad++;
          $display("FAIL sb_unexpected lane=%0d got=%0h exp=none", out_lane_o, out_pkt_o);
        end else if (out_pkt_o !== exp_pkt) begin
          bad++;
          $display("FAIL sb_pkt lane=%0d got=%0h exp=%0h", out_lane_o, out_pkt_o, exp_pkt);
        end
      end
      if (simple_valid_i && simple_ready_o)   q_s.push_back(simple_pkt_i);
      if (complex_valid_i && complex_ready_o) q_c.push_back(complex_pkt_i);
      if (fp_valid_i && fp_ready_o)           q_f.push_back(fp_pkt_i);
    end
  end

  // Occupancy bounds; an underflow wraps the count above DEPTH as well.
  always @(negedge clk) begin
    if (reset) begin
      assert (simple_cnt_o <= DEPTH_C)  else $error("simple count out of range %0d", simple_cnt_o);
      assert (complex_cnt_o <= DEPTH_C) else $error("complex count out of range %0d", complex_cnt_o);
      assert (fp_cnt_o <= DEPTH_C)      else $error("fp count out of range %0d", fp_cnt_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid_o, out_lane_o} !== 3'b000) begin
      bad++; $display("FAIL reset_valid_lane got=%0h exp=0", {out_valid_o, out_lane_o});
    end
    total++;
    if (out_pkt_o !== 80'h0) begin
      bad++; $display("FAIL reset_pkt got=%0h exp=0", out_pkt_o);
    end
    total++;
    if ({simple_cnt_o, complex_cnt_o, fp_cnt_o} !== 6'b000000) begin
      bad++; $display("FAIL reset_counts got=%0h exp=0", {simple_cnt_o, complex_cnt_o, fp_cnt_o});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({simple_ready_o, complex_ready_o, fp_ready_o} !== 3'b111) begin
      bad++; $display("FAIL reset_ready got=%0b exp=111", {simple_ready_o, complex_ready_o, fp_ready_o});
    end
  endtask

  task automatic test_single();
    tick();
    out_ready_i = 1'b1; simple_valid_i = 1'b1; simple_pkt_i = 80'hA5;
    @(negedge clk);
    total++;
    if (simple_cnt_o !== 2'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", simple_cnt_o); end
    tick();
    simple_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid_o, simple_cnt_o} !== 3'b001) begin
      bad++; $display("FAIL single_cnt1 got=%0b exp=001", {out_valid_o, simple_cnt_o});
    end
    @(negedge clk);
    total++;
    if ({out_valid_o, out_lane_o, simple_cnt_o} !== 5'b10000 || out_pkt_o !== 80'hA5) begin
      bad++; $display("FAIL single_out got=%0b/%0h exp=10000/a5", {out_valid_o, out_lane_o, simple_cnt_o}, out_pkt_o);
    end
    @(negedge clk);
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", out_valid_o); end
  endtask

  task automatic test_backpressure();
    int g;
    tick();
    out_ready_i = 1'b0; complex_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      complex_pkt_i = 80'(i);
      g = 0;
      do begin @(negedge clk); g++; end while (!complex_ready_o && g < 20);
      total++;
      if (!complex_ready_o) begin bad++; $display("FAIL bp_accept_timeout got=0 exp=1 item=%0d", i); end
      tick();
    end
    complex_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid_o, out_lane_o, complex_cnt_o, complex_ready_o} !== 6'b101100 || out_pkt_o !== 80'h1) begin
      bad++;
      $display("FAIL bp_held got=%0b/%0h exp=101100/1", {out_valid_o, out_lane_o, complex_cnt_o, complex_ready_o}, out_pkt_o);
    end
    tick();
    out_ready_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      total++;
      if (!out_valid_o || out_pkt_o !== 80'(k) || out_lane_o !== 2'd1) begin
        bad++; $display("FAIL bp_drain%0d got=%0b/%0h exp=1/%0h", k, out_valid_o, out_pkt_o, k);
      end
    end
    @(negedge clk);
    total++;
    if ({out_valid_o, complex_cnt_o} !== 3'b000) begin
      bad++; $display("FAIL bp_empty got=%0b exp=000", {out_valid_o, complex_cnt_o});
    end
  endtask

  task automatic test_round_robin();
    int sent[3];
    logic [1:0] seen[$];
    int g;
    sent = '{0, 0, 0};
    out_ready_i = 1'b1;
    do_flush();
    for (int c = 0; c < 14; c++) begin
      tick();
      simple_valid_i  = (sent[0] < 4) ? 1'b1 : 1'b0; simple_pkt_i  = 80'h100 + 80'(sent[0]);
      complex_valid_i = (sent[1] < 4) ? 1'b1 : 1'b0; complex_pkt_i = 80'h200 + 80'(sent[1]);
      fp_valid_i      = (sent[2] < 4) ? 1'b1 : 1'b0; fp_pkt_i      = 80'h300 + 80'(sent[2]);
      @(negedge clk);
      if (out_valid_o) seen.push_back(out_lane_o);
      if (simple_valid_i && simple_ready_o)   sent[0]++;
      if (complex_valid_i && complex_ready_o) sent[1]++;
      if (fp_valid_i && fp_ready_o)           sent[2]++;
    end
    tick();
    simple_valid_i = 1'b0; complex_valid_i = 1'b0; fp_valid_i = 1'b0;
    total++;
    if (seen.size() < 6) begin
      bad++; $display("FAIL rr_count got=%0d exp=6", seen.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (seen[i] !== 2'(i % 3)) begin bad++; $display("FAIL rr_lane%0d got=%0d exp=%0d", i, seen[i], i % 3); end
      end
    end
    g = 0;
    while ((out_valid_o || simple_cnt_o != 2'd0 || complex_cnt_o != 2'd0 || fp_cnt_o != 2'd0) && g < 30) begin
      @(negedge clk); g++;
    end
    total++;
    if (g >= 30) begin bad++; $display("FAIL rr_drain_timeout got=busy exp=idle"); end
  endtask

  task automatic test_skip_empty();
    logic [1:0] seen[$];
    do_flush();
    tick();
    simple_valid_i = 1'b1; simple_pkt_i = 80'h4A0;
    tick();
    simple_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    simple_valid_i = 1'b1; simple_pkt_i = 80'h4B0;
    fp_valid_i = 1'b1; fp_pkt_i = 80'h4C0;
    tick();
    simple_valid_i = 1'b0; fp_valid_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid_o) seen.push_back(out_lane_o);
    end
    total++;
    if (seen.size() != 2) begin
      bad++; $display("FAIL skip_count got=%0d exp=2", seen.size());
    end else if (seen[0] !== 2'd2 || seen[1] !== 2'd0) begin
      bad++; $display("FAIL skip_order got=%0d,%0d exp=2,0", seen[0], seen[1]);
    end
  endtask

  task automatic test_flush();
    logic [1:0] seen[$];
    logic [PKT_W-1:0] pk[$];
    do_flush();
    tick();
    out_ready_i = 1'b0;
    simple_valid_i = 1'b1; complex_valid_i = 1'b1; fp_valid_i = 1'b1;
    simple_pkt_i = 80'h501; complex_pkt_i = 80'h601; fp_pkt_i = 80'h701;
    tick();
    complex_valid_i = 1'b0; simple_pkt_i = 80'h502; fp_pkt_i = 80'h702;
    tick();
    fp_valid_i = 1'b0; simple_pkt_i = 80'h503;
    tick();
    simple_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o} !== 7'b1001101 || out_pkt_o !== 80'h501) begin
      bad++;
      $display("FAIL flush_setup got=%0b/%0h exp=1001101/501", {simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o}, out_pkt_o);
    end
    tick();
    flush_i = 1'b1; simple_valid_i = 1'b1; simple_pkt_i = 80'h5FF;
    tick();
    flush_i = 1'b0; simple_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if ({simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o} !== 7'b0000000) begin
      bad++; $display("FAIL flush_clear got=%0b exp=0000000", {simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o});
    end
    total++;
    if (out_pkt_o !== 80'h501) begin bad++; $display("FAIL flush_stale_pkt got=%0h exp=501", out_pkt_o); end
    tick();
    simple_valid_i = 1'b1; simple_pkt_i = 80'h5A0;
    fp_valid_i = 1'b1; fp_pkt_i = 80'h7A0;
    tick();
    simple_valid_i = 1'b0; fp_valid_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid_o) begin seen.push_back(out_lane_o); pk.push_back(out_pkt_o); end
    end
    total++;
    if (seen.size() != 2) begin
      bad++; $display("FAIL flush_after_count got=%0d exp=2", seen.size());
    end else if (seen[0] !== 2'd0 || pk[0] !== 80'h5A0 || seen[1] !== 2'd2 || pk[1] !== 80'h7A0) begin
      bad++; $display("FAIL flush_after got=%0d:%0h,%0d:%0h exp=0:5a0,2:7a0", seen[0], pk[0], seen[1], pk[1]);
    end
  endtask

  task automatic test_async_reset();
    tick();
    out_ready_i = 1'b0;
    simple_valid_i = 1'b1; complex_valid_i = 1'b1; fp_valid_i = 1'b1;
    simple_pkt_i = 80'h801; complex_pkt_i = 80'h802; fp_pkt_i = 80'h803;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o} !== 7'b1010101) begin
      bad++; $display("FAIL areset_full got=%0b exp=1010101", {simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o});
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    simple_valid_i = 1'b0; complex_valid_i = 1'b0; fp_valid_i = 1'b0;
    #1;
    total++;
    if ({simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o} !== 7'b0000000 || out_pkt_o !== 80'h0) begin
      bad++;
      $display("FAIL areset_now got=%0b/%0h exp=0000000/0", {simple_cnt_o, complex_cnt_o, fp_cnt_o, out_valid_o}, out_pkt_o);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({simple_ready_o, complex_ready_o, fp_ready_o, out_valid_o} !== 4'b1110) begin
      bad++; $display("FAIL areset_release got=%0b exp=1110", {simple_ready_o, complex_ready_o, fp_ready_o, out_valid_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] got[$];
    int idx[$];
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      simple_valid_i = (c < 4) ? 1'b1 : 1'b0;
      simple_pkt_i = 80'h900 + 80'(c);
      @(negedge clk);
      if (out_valid_o) begin got.push_back(out_pkt_o); idx.push_back(c); end
    end
    tick();
    simple_valid_i = 1'b0;
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== 80'h900 + 80'(i) || (i > 0 && idx[i] != idx[i-1] + 1)) begin
          bad++; $display("FAIL b2b_item%0d got=%0h@%0d exp=%0h consecutive", i, got[i], idx[i], 80'h900 + 80'(i));
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    simple_valid_i = 1'b0; complex_valid_i = 1'b0; fp_valid_i = 1'b0;
    simple_pkt_i = '0; complex_pkt_i = '0; fp_pkt_i = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_skip_empty();
    test_flush();
    test_async_reset();
    test_back_to_back();
    repeat (4) @(negedge clk);
    total++;
    if (q_s.size() + q_c.size() + q_f.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d exp=0", q_s.size() + q_c.size() + q_f.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
